// File: rtl/pn_frame_ctrl.sv
// Sequencing controller for the PN spreading generator: seeds it, gates its advance,
// frames a preamble followed by data symbols, and registers the spread chip stream.
module pn_frame_ctrl #(
  parameter int                LFSR_W        = 4,
  parameter int                CHIPS_PER_BIT = 15,
  parameter logic [LFSR_W-1:0] SEED          = {{(LFSR_W-1){1'b0}}, 1'b1},
  parameter int                PREAMBLE_BITS = 8
) (
  input  logic              clk_sig,
  input  logic              rst_sig,
  input  logic              start_sig,
  input  logic              stop_sig,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              bit_ready,
  output logic              pn_load,
  output logic [LFSR_W-1:0] pn_seed,
  output logic              pn_en,
  input  logic              pn_chip,
  output logic              chip_valid,
  output logic              chip_sig,
  output logic              sym_start,
  output logic              busy,
  output logic              underrun
);

  localparam int CNT_W = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
  localparam int BIT_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CHIPS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_PRE  = BIT_W'(PREAMBLE_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PREAMBLE,
    DATA
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] chip_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             cur_bit;
  logic             stop_pend;
  logic             sym_last;
  logic             at_boundary;

  assign pn_seed  = SEED;
  assign busy     = (state != IDLE);
  assign pn_load  = (state == LOAD);
  assign pn_en    = (state == PREAMBLE) || (state == DATA);
  assign sym_last = (chip_cnt == LAST_CHIP);

  // A new bit is taken only where the next symbol will carry data: every DATA
  // boundary and the final preamble boundary, and never while a stop is pending.
  assign at_boundary = sym_last &&
                       ((state == DATA) || ((state == PREAMBLE) && (bit_cnt == LAST_PRE)));
  assign bit_ready   = at_boundary & ~stop_pend & ~stop_sig;

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      state      <= IDLE;
      chip_cnt   <= '0;
      bit_cnt    <= '0;
      cur_bit    <= 1'b0;
      stop_pend  <= 1'b0;
      underrun   <= 1'b0;
      chip_valid <= 1'b0;
      chip_sig   <= 1'b0;
      sym_start  <= 1'b0;
    end else begin
      chip_valid <= pn_en;
      chip_sig   <= pn_chip ^ cur_bit;
      sym_start  <= pn_en && (chip_cnt == '0);

      case (state)
        IDLE: begin
          cur_bit   <= 1'b0;
          stop_pend <= 1'b0;
          chip_cnt  <= '0;
          bit_cnt   <= '0;
          if (start_sig) begin
            state    <= LOAD;
            underrun <= 1'b0;
          end
        end

        LOAD: begin
          chip_cnt <= '0;
          bit_cnt  <= '0;
          if (stop_sig) stop_pend <= 1'b1;
          state <= PREAMBLE;
        end

        PREAMBLE, DATA: begin
          if (stop_sig) stop_pend <= 1'b1;
          if (sym_last) begin
            chip_cnt <= '0;
            // Symbol alignment with the generator holds because the symbol length
            // equals the PN period, so the generator is never reloaded mid-frame.
            if (stop_pend || stop_sig) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
              cur_bit   <= 1'b0;
            end else if ((state == PREAMBLE) && (bit_cnt != LAST_PRE)) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
              if (bit_valid) begin
                cur_bit <= bit_data;
              end else begin
                cur_bit  <= 1'b0;
                underrun <= 1'b1;
              end
            end
          end else begin
            chip_cnt <= chip_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pn_frame_ctrl.sv
// Scoreboard bench for pn_frame_ctrl: a model 4-bit generator feeds pn_chip, expected
// chips are queued as stimulus is issued and a negedge monitor compares them.
module tb_pn_frame_ctrl;

  logic       clk_sig = 1'b0;
  logic       rst_sig;
  logic       start_sig;
  logic       stop_sig;
  logic       bit_valid;
  logic       bit_data;
  logic       bit_ready;
  logic       pn_load;
  logic [3:0] pn_seed;
  logic       pn_en;
  logic       pn_chip;
  logic       chip_valid;
  logic       chip_sig;
  logic       sym_start;
  logic       busy;
  logic       underrun;

  typedef struct packed {
    logic chip;
    logic sos;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Output of x^4+x^3+1 from seed 0001, one entry per chip of a period.
  bit pn_ref [0:14] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};

  logic [3:0] gen_q = 4'b0000;

  always #5 clk_sig = ~clk_sig;

  always @(posedge clk_sig) begin
    if (pn_load)    gen_q <= pn_seed;
    else if (pn_en) gen_q <= {gen_q[2:0], gen_q[3] ^ gen_q[2]};
  end
  assign pn_chip = gen_q[3];

  pn_frame_ctrl #(
    .LFSR_W       (4),
    .CHIPS_PER_BIT(15),
    .SEED         (4'b0001),
    .PREAMBLE_BITS(2)
  ) dut (
    .clk_sig   (clk_sig),
    .rst_sig   (rst_sig),
    .start_sig (start_sig),
    .stop_sig  (stop_sig),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .bit_ready (bit_ready),
    .pn_load   (pn_load),
    .pn_seed   (pn_seed),
    .pn_en     (pn_en),
    .pn_chip   (pn_chip),
    .chip_valid(chip_valid),
    .chip_sig  (chip_sig),
    .sym_start (sym_start),
    .busy      (busy),
    .underrun  (underrun)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every valid chip must match the head of the expected queue.
  always @(negedge clk_sig) begin
    if (chip_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_chip: got chip %0d, expected no chip_valid", chip_sig);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("chip_sig", chip_sig, e.chip);
        checkOutput("sym_start", sym_start, e.sos);
      end
    end
  end

  task automatic tick();
    @(negedge clk_sig);
    cyc++;
  endtask

  task automatic gotoCycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic valid,
                               input logic data);
    start_sig = start;
    stop_sig  = stop;
    bit_valid = valid;
    bit_data  = data;
  endtask

  task automatic pushChips(input bit b, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.chip = pn_ref[k] ^ b;
      e.sos  = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bit_ready"}, bit_ready, 0);
    checkOutput({tag, "_pn_load"}, pn_load, 0);
    checkOutput({tag, "_pn_en"}, pn_en, 0);
    checkOutput({tag, "_chip_valid"}, chip_valid, 0);
    checkOutput({tag, "_chip_sig"}, chip_sig, 0);
    checkOutput({tag, "_sym_start"}, sym_start, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_underrun"}, underrun, 0);
    checkOutput({tag, "_pn_seed"}, pn_seed, 1);
  endtask

  // Issues start at the current negedge (cycle 0) and checks the LOAD/first-chip timing.
  task automatic startFrame();
    cyc = 0;
    start_sig = 1'b1;
    pushChips(0, 15);
    pushChips(0, 15);
    tick();
    start_sig = 1'b0;
    checkOutput("load_pn_load", pn_load, 1);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_pn_en", pn_en, 0);
    checkOutput("load_underrun", underrun, 0);
    tick();
    checkOutput("pre_pn_load", pn_load, 0);
    checkOutput("pre_pn_en", pn_en, 1);
    checkOutput("pre_chip_valid", chip_valid, 0);
    tick();
    checkOutput("first_chip_valid", chip_valid, 1);
    checkOutput("first_sym_start", sym_start, 1);
  endtask

  initial begin
    rst_sig = 1'b1;
    applyStimulus(0, 0, 0, 0);
    repeat (3) @(negedge clk_sig);
    checkAllZero("reset");
    rst_sig = 1'b0;
    repeat (2) @(negedge clk_sig);

    // Frame A: data 1,0,1 then an underrun symbol, a stray start, and a stop.
    applyStimulus(0, 0, 1, 1);
    startFrame();
    gotoCycle(16);
    checkOutput("pre_mid_boundary_ready", bit_ready, 0);
    gotoCycle(31);
    checkOutput("pre_last_boundary_ready", bit_ready, 1);
    pushChips(1, 15);
    tick();
    bit_data = 1'b0;
    checkOutput("ready_not_boundary", bit_ready, 0);
    gotoCycle(46);
    checkOutput("data0_boundary_ready", bit_ready, 1);
    pushChips(0, 15);
    tick();
    bit_data = 1'b1;
    gotoCycle(50);
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
    checkOutput("stray_start_pn_load", pn_load, 0);
    checkOutput("stray_start_busy", busy, 1);
    gotoCycle(61);
    checkOutput("data1_boundary_ready", bit_ready, 1);
    pushChips(1, 15);
    tick();
    bit_valid = 1'b0;
    checkOutput("underrun_before", underrun, 0);
    gotoCycle(76);
    checkOutput("underrun_boundary_ready", bit_ready, 1);
    checkOutput("underrun_not_yet", underrun, 0);
    pushChips(0, 15);
    tick();
    checkOutput("underrun_set", underrun, 1);
    tick();
    applyStimulus(0, 0, 1, 1);
    gotoCycle(82);
    stop_sig = 1'b1;
    tick();
    stop_sig = 1'b0;
    gotoCycle(91);
    checkOutput("stop_boundary_ready", bit_ready, 0);
    checkOutput("stop_boundary_busy", busy, 1);
    tick();
    checkOutput("stopped_busy", busy, 0);
    checkOutput("stopped_pn_en", pn_en, 0);
    checkOutput("stopped_last_chip_valid", chip_valid, 1);
    checkOutput("underrun_sticky", underrun, 1);
    tick();
    checkOutput("stopped_chip_valid", chip_valid, 0);
    gotoCycle(98);
    checkOutput("underrun_sticky_idle", underrun, 1);
    checkOutput("frame_a_drained", exp_q.size(), 0);

    // Frame B: restart clears underrun, then reset lands at chip 7 of the first data symbol.
    applyStimulus(0, 0, 1, 0);
    startFrame();
    gotoCycle(31);
    checkOutput("b_boundary_ready", bit_ready, 1);
    pushChips(0, 7);
    gotoCycle(39);
    rst_sig = 1'b1;
    tick();
    checkAllZero("midreset");
    checkOutput("frame_b_drained", exp_q.size(), 0);
    rst_sig = 1'b0;
    repeat (2) tick();

    // Frame C: identical start-up after reset, then stop during the second preamble symbol.
    applyStimulus(0, 0, 1, 0);
    startFrame();
    gotoCycle(20);
    stop_sig = 1'b1;
    tick();
    stop_sig = 1'b0;
    gotoCycle(31);
    checkOutput("c_stop_boundary_ready", bit_ready, 0);
    tick();
    checkOutput("c_stopped_busy", busy, 0);
    gotoCycle(35);
    checkOutput("c_chip_valid_idle", chip_valid, 0);
    checkOutput("frame_c_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pn_frame_ctrl.md
Name: pn_frame_ctrl

Overview:
- Sequencing controller for the m-sequence (PN) generator in the BPSK transmit chain.
- Loads the generator seed, gates its advance, and frames the transmission as a preamble followed by data symbols.
- Accepts data bits over a valid/ready handshake and spreads each bit across one full PN period (chip = pn XOR bit).
- Drives the registered chip stream to the BPSK modulator.

Parameters:
- LFSR_W, 4, generator register width; width of pn_seed.
- CHIPS_PER_BIT, 15, chips per symbol; equals the PN period (2^LFSR_W-1).
- SEED, 4'b0001, seed value driven on pn_seed; must be nonzero.
- PREAMBLE_BITS, 8, number of zero-data symbols sent after each start; must be ≥1.

Ports:
- clk_sig  in  1  system clock; all logic on the rising edge.
- rst_sig  in  1  synchronous, active-high reset.
- start_sig  in  1  one-cycle request to begin a frame; ignored unless IDLE.
- stop_sig  in  1  request to end the frame at the next symbol boundary.
- bit_valid  in  1  data bit available.
- bit_data  in  1  data bit.
- bit_ready  out  1  controller accepts bit_data this cycle.
- pn_load  out  1  generator loads pn_seed at this edge.
- pn_seed  out  LFSR_W  constant SEED.
- pn_en  out  1  generator advances at this edge; pn_chip is valid this cycle.
- pn_chip  in  1  current generator output; combinational from generator state.
- chip_valid  out  1  chip_sig is valid.
- chip_sig  out  1  spread chip.
- sym_start  out  1  marks the first chip of each symbol; coincident with chip_valid.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  sticky flag: a data symbol was sent with no bit available.

Behaviour:
- Reset values:
  - state=IDLE.
  - bit_ready, pn_load, pn_en, chip_valid, chip_sig, sym_start, busy, underrun are all 0.
  - pn_seed=SEED at all times.
  - Chip and bit counters are 0; cur_bit=0; stop_pend=0.
  - Reset asserted mid-frame aborts the frame; all outputs take their reset values at the next edge.
- States: IDLE, LOAD, PREAMBLE, DATA. The state register is registered; pn_load, pn_en, busy and bit_ready are decoded from state and counters.
- IDLE:
  - start_sig=1 → LOAD.
  - underrun cleared.
  - cur_bit=0.
- LOAD:
  - Lasts exactly one cycle; pn_load=1, pn_en=0.
  - → PREAMBLE with chip_cnt=0, bit_cnt=0.
- PREAMBLE / DATA:
  - pn_en=1 every cycle.
  - chip_cnt counts 0..CHIPS_PER_BIT-1 and wraps to 0.
  - In PREAMBLE, cur_bit=0.
  - At the end of the last preamble symbol, the state moves to DATA.
- Symbol boundary (chip_cnt=CHIPS_PER_BIT-1):
  - Applies in DATA, and in PREAMBLE when bit_cnt=PREAMBLE_BITS-1.
  - bit_ready = ~stop_pend & ~stop_sig.
  - If bit_valid & bit_ready: cur_bit←bit_data for the next symbol.
  - If bit_ready & ~bit_valid: cur_bit←0 and underrun←1.
  - bit_ready is 0 in all other cycles.
- Output register, updated each cycle:
  - chip_valid←pn_en.
  - chip_sig←pn_chip XOR cur_bit (current symbol's bit).
  - sym_start←pn_en & (chip_cnt==0).
  - chip_valid lags pn_en by exactly 1 cycle.
- Stop:
  - stop_sig in PREAMBLE or DATA sets stop_pend.
  - The current symbol completes in full; on its last chip the state goes to IDLE.
  - stop_pend is cleared on entering IDLE.
  - stop_sig in IDLE or LOAD: no effect in IDLE; in LOAD it is latched and takes effect at the end of the first symbol.
  - stop_sig and start_sig together in IDLE: start wins, stop is ignored.
- No PN reload is performed mid-frame; alignment relies on CHIPS_PER_BIT equal to the PN period.

Test Plan (LFSR_W=4, CHIPS_PER_BIT=15, PREAMBLE_BITS=2, SEED=1, reference generator model):
- Reset, then start_sig pulse at cycle t:
  - pn_load=1 and busy=1 in t+1 only.
  - pn_en=1 from t+2.
  - First chip_valid=1 with sym_start=1 at t+3.
  - 30 preamble chips equal the model PN sequence, with sym_start at chips 0 and 15.
- Bits 1,0,1 held valid:
  - bit_ready pulses at chip 14 of each symbol.
  - Data symbols output inverted PN, direct PN, inverted PN.
  - underrun stays 0.
- bit_valid held 0 at a data boundary:
  - underrun=1 from the next cycle and stays high.
  - That symbol equals PN.
  - underrun clears only on the next start from IDLE.
- stop_sig at chip 5 of a data symbol:
  - Chips 6..14 are still output.
  - No bit_ready at that boundary.
  - busy=0 after the boundary; chip_valid=0 one cycle later.
- Reset at chip 7 of DATA: every output is 0 at the next edge; a subsequent start reproduces the first scenario exactly.
- start_sig pulsed during DATA: ignored, with no pn_load and no disturbance to the chip sequence.
